// File: rtl/raster_pkg.sv
// Shared types and field layout for the frame-level triangle scheduler.
// Vertex words are {x[9:0], y[9:0]}; a triangle word is {A, B, C}.
package raster_pkg;

    localparam int VERT_W = 20;
    localparam int TRI_W  = 60;
    localparam int X_MSB  = 19;
    localparam int X_LSB  = 10;
    localparam int Y_MSB  = 9;
    localparam int Y_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_RASTER,
        S_DONE
    } sched_state_t;

    // k = 0 selects vertex A, 1 selects B, 2 selects C
    function automatic logic [VERT_W-1:0] tri_vert(
        input logic [TRI_W-1:0] t,
        input int               k
    );
        return t[TRI_W-1-k*VERT_W -: VERT_W];
    endfunction

endpackage

// File: rtl/rd_latency_tracker.sv
// Loadable down-counter that flags when a RAM read issued at load
// time has had READ_LATENCY cycles to settle.
module rd_latency_tracker #(
    parameter  int LATENCY = 2,
    localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic load,
    output logic data_ready
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    assign data_ready = active_q && (cnt_q == '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            cnt_q    <= LOAD_VAL;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0)
                active_q <= 1'b0;
            else
                cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/raster_scheduler.sv
// Frame sequencer: fetches triangles from vertex RAM and feeds the rasterizer.
// Define RASTER_SCHED_CLEAR_EN to add a framebuffer clear sweep per frame.
module raster_scheduler
    import raster_pkg::*;
#(
    parameter  int MAX_TRIS     = 72,
    parameter  int READ_LATENCY = 2,
    parameter  int TIMEOUT      = 2**20,
    parameter  int WIDTH        = 1024,
    parameter  int HEIGHT       = 720,
    localparam int ADDR_W       = $clog2(MAX_TRIS),
    localparam int PIX_W        = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              frame_start_in,
    input  logic [ADDR_W:0]   tri_count_in,
    output logic [ADDR_W-1:0] tri_addr_out,
    input  logic [TRI_W-1:0]  tri_data_in,
    output logic              rast_valid_out,
    output logic [VERT_W-1:0] rast_vertex_a_out,
    output logic [VERT_W-1:0] rast_vertex_b_out,
    output logic [VERT_W-1:0] rast_vertex_c_out,
    output logic [ADDR_W-1:0] rast_tri_idx_out,
    input  logic              rast_last_in,
`ifdef RASTER_SCHED_CLEAR_EN
    output logic              clear_we_out,
    output logic [PIX_W-1:0]  clear_addr_out,
    output logic [23:0]       clear_data_out,
    input  logic [23:0]       bg_color_in,
`endif
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              timeout_err_out
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W:0]  MAX_N   = (ADDR_W + 1)'(MAX_TRIS);
    localparam logic [ADDR_W:0]  IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
`ifdef RASTER_SCHED_CLEAR_EN
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(WIDTH * HEIGHT - 1);
`endif

    if (READ_LATENCY < 1 || TIMEOUT < 2 || MAX_TRIS < 2 ||
        WIDTH * HEIGHT < 2) begin : g_bad_cfg
        $error("raster_scheduler: unsupported parameter set");
    end

    sched_state_t    state;
    logic [ADDR_W:0] n_q;
    logic [ADDR_W:0] idx_q;
    logic [ADDR_W:0] n_next;
    logic [WD_W-1:0] wd_q;
    logic            rd_ready;
    logic            last_tri;

    assign n_next   = (tri_count_in > MAX_N) ? MAX_N : tri_count_in;
    assign last_tri = ((idx_q + IDX_ONE) == n_q);

    rd_latency_tracker #(
        .LATENCY    (READ_LATENCY)
    ) u_rd_lat (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load       (state == S_FETCH),
        .data_ready (rd_ready)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= S_IDLE;
            n_q               <= '0;
            idx_q             <= '0;
            wd_q              <= '0;
            tri_addr_out      <= '0;
            rast_valid_out    <= 1'b0;
            rast_vertex_a_out <= '0;
            rast_vertex_b_out <= '0;
            rast_vertex_c_out <= '0;
            rast_tri_idx_out  <= '0;
            busy_out          <= 1'b0;
            frame_done_out    <= 1'b0;
            timeout_err_out   <= 1'b0;
`ifdef RASTER_SCHED_CLEAR_EN
            clear_we_out      <= 1'b0;
            clear_addr_out    <= '0;
            clear_data_out    <= '0;
`endif
        end else begin
            rast_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        n_q             <= n_next;
                        idx_q           <= '0;
                        busy_out        <= 1'b1;
                        timeout_err_out <= 1'b0;
`ifdef RASTER_SCHED_CLEAR_EN
                        state          <= S_CLEAR;
                        clear_we_out   <= 1'b1;
                        clear_addr_out <= '0;
                        clear_data_out <= bg_color_in;
`else
                        state <= (n_next == '0) ? S_DONE : S_FETCH;
`endif
                    end
                end
                S_CLEAR: begin
`ifdef RASTER_SCHED_CLEAR_EN
                    clear_data_out <= bg_color_in;
                    if (clear_addr_out == PIX_LAST) begin
                        clear_we_out <= 1'b0;
                        state <= (n_q == '0) ? S_DONE : S_FETCH;
                    end else begin
                        clear_addr_out <= clear_addr_out + 1'b1;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_FETCH: begin
                    tri_addr_out <= idx_q[ADDR_W-1:0];
                    state        <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (rd_ready) begin
                        rast_vertex_a_out <= tri_vert(tri_data_in, 0);
                        rast_vertex_b_out <= tri_vert(tri_data_in, 1);
                        rast_vertex_c_out <= tri_vert(tri_data_in, 2);
                        rast_tri_idx_out  <= idx_q[ADDR_W-1:0];
                        rast_valid_out    <= 1'b1;
                        state             <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_q  <= '0;
                    state <= S_RASTER;
                end
                S_RASTER: begin
                    // a real last wins over a simultaneous watchdog expiry
                    if (rast_last_in || wd_q == WD_LAST) begin
                        if (!rast_last_in)
                            timeout_err_out <= 1'b1;
                        if (last_tri) begin
                            state <= S_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                            state <= S_FETCH;
                        end
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_DONE: begin
                    frame_done_out <= 1'b1;
                    busy_out       <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_scheduler.sv
// Directed bench for raster_scheduler: issue order, latency, clamp,
// watchdog abort, ignored controls and mid-frame reset.
module tb_raster_scheduler;
    import raster_pkg::*;

    localparam int MAX_TRIS = 72;
    localparam int AW       = 7;
    localparam int PW       = 3;
    localparam logic [23:0] BG = 24'h3355AA;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              frame_start_in;
    logic [AW:0]       tri_count_in;
    logic [AW-1:0]     tri_addr_out;
    logic [TRI_W-1:0]  tri_data_in;
    logic              rast_valid_out;
    logic [VERT_W-1:0] rast_vertex_a_out;
    logic [VERT_W-1:0] rast_vertex_b_out;
    logic [VERT_W-1:0] rast_vertex_c_out;
    logic [AW-1:0]     rast_tri_idx_out;
    logic              rast_last_in;
    logic              busy_out;
    logic              frame_done_out;
    logic              timeout_err_out;
`ifdef RASTER_SCHED_CLEAR_EN
    logic              clear_we_out;
    logic [PW-1:0]     clear_addr_out;
    logic [23:0]       clear_data_out;
    logic [23:0]       bg_color_in;
    assign bg_color_in = BG;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    int   pulse_cnt = 0;
    int   done_cnt = 0;
    int   clr_cnt = 0;
    int   last_idx = -1;
    int   skip_idx = -1;
    bit   model_en = 1'b1;
    logic model_last = 1'b0;
    logic man_last = 1'b0;

    assign rast_last_in = model_last | man_last;

    always #5 clk_in = ~clk_in;

    raster_scheduler #(
        .MAX_TRIS          (MAX_TRIS),
        .READ_LATENCY      (2),
        .TIMEOUT           (64),
        .WIDTH             (4),
        .HEIGHT            (2)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .frame_start_in    (frame_start_in),
        .tri_count_in      (tri_count_in),
        .tri_addr_out      (tri_addr_out),
        .tri_data_in       (tri_data_in),
        .rast_valid_out    (rast_valid_out),
        .rast_vertex_a_out (rast_vertex_a_out),
        .rast_vertex_b_out (rast_vertex_b_out),
        .rast_vertex_c_out (rast_vertex_c_out),
        .rast_tri_idx_out  (rast_tri_idx_out),
        .rast_last_in      (rast_last_in),
`ifdef RASTER_SCHED_CLEAR_EN
        .clear_we_out      (clear_we_out),
        .clear_addr_out    (clear_addr_out),
        .clear_data_out    (clear_data_out),
        .bg_color_in       (bg_color_in),
`endif
        .busy_out          (busy_out),
        .frame_done_out    (frame_done_out),
        .timeout_err_out   (timeout_err_out)
    );

    function automatic logic [VERT_W-1:0] mk(input logic [9:0] x,
                                             input logic [9:0] y);
        logic [VERT_W-1:0] v;
        v = '0;
        v[X_MSB:X_LSB] = x;
        v[Y_MSB:Y_LSB] = y;
        return v;
    endfunction

    function automatic logic [TRI_W-1:0] tri_word(input int i);
        return {mk(10'(i * 7 + 1), 10'(i * 3 + 2)),
                mk(10'(1000 - i), 10'(700 - i)),
                mk(10'(i * 13), 10'(i + 100))};
    endfunction

    // two-cycle RAM: address registered by the DUT, one output register here
    always @(posedge clk_in)
        tri_data_in <= tri_word(int'(tri_addr_out));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (rast_valid_out) begin
            chk("issue_idx", 64'(rast_tri_idx_out), 64'(pulse_cnt));
            chk("ram_addr", 64'(tri_addr_out), 64'(pulse_cnt));
            chk("vert_a", 64'(rast_vertex_a_out),
                64'(tri_word(pulse_cnt)[59:40]));
            chk("vert_b", 64'(rast_vertex_b_out),
                64'(tri_word(pulse_cnt)[39:20]));
            chk("vert_c", 64'(rast_vertex_c_out),
                64'(tri_word(pulse_cnt)[19:0]));
            last_idx = int'(rast_tri_idx_out);
            pulse_cnt++;
        end
        if (frame_done_out)
            done_cnt++;
`ifdef RASTER_SCHED_CLEAR_EN
        if (clear_we_out) begin
            chk("clear_addr", 64'(clear_addr_out), 64'(clr_cnt));
            chk("clear_data", 64'(clear_data_out), 64'(BG));
            clr_cnt++;
        end
`endif
    end

    // rasterizer model: last pulse 10 cycles after valid
    always begin
        @(negedge clk_in);
        if (model_en && rast_valid_out &&
            int'(rast_tri_idx_out) != skip_idx) begin
            repeat (10) @(negedge clk_in);
            model_last = 1'b1;
            @(negedge clk_in);
            model_last = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_frame(input int n);
        pulse_cnt      = 0;
        done_cnt       = 0;
        clr_cnt        = 0;
        last_idx       = -1;
        tri_count_in   = (AW + 1)'(n);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!frame_done_out && k < budget) begin
            tick();
            k++;
        end
        chk("frame_done_seen", 64'(frame_done_out), 64'(1));
    endtask

    task automatic wait_valid(input int want, input int budget);
        int k = 0;
        while (!(rast_valid_out && int'(rast_tri_idx_out) == want) &&
               k < budget) begin
            tick();
            k++;
        end
        chk("valid_seen", 64'(rast_valid_out), 64'(1));
    endtask

    initial begin
        rst_n_in       = 1'b0;
        frame_start_in = 1'b0;
        tri_count_in   = '0;
        repeat (2) tick();
        chk("rst_busy", 64'(busy_out), 64'(0));
        chk("rst_valid", 64'(rast_valid_out), 64'(0));
        chk("rst_done", 64'(frame_done_out), 64'(0));
        chk("rst_err", 64'(timeout_err_out), 64'(0));
        chk("rst_addr", 64'(tri_addr_out), 64'(0));
        chk("rst_vert_a", 64'(rast_vertex_a_out), 64'(0));
        rst_n_in = 1'b1;
        tick();

        // three triangles, first issue four edges after start
        start_frame(3);
        chk("t1_busy", 64'(busy_out), 64'(1));
`ifndef RASTER_SCHED_CLEAR_EN
        tick();
        tick();
        chk("t1_valid_early", 64'(rast_valid_out), 64'(0));
        tick();
        chk("t1_valid_t4", 64'(rast_valid_out), 64'(1));
`endif
        wait_done(2000);
        chk("t1_busy_at_done", 64'(busy_out), 64'(0));
        tick();
        chk("t1_pulses", 64'(pulse_cnt), 64'(3));
        chk("t1_last_idx", 64'(last_idx), 64'(2));
        chk("t1_done_cnt", 64'(done_cnt), 64'(1));
        chk("t1_err", 64'(timeout_err_out), 64'(0));

        // empty frame
        start_frame(0);
`ifndef RASTER_SCHED_CLEAR_EN
        chk("t2_done_early", 64'(frame_done_out), 64'(0));
        chk("t2_busy", 64'(busy_out), 64'(1));
        tick();
        chk("t2_done", 64'(frame_done_out), 64'(1));
        chk("t2_busy_low", 64'(busy_out), 64'(0));
`else
        wait_done(100);
`endif
        tick();
        chk("t2_pulses", 64'(pulse_cnt), 64'(0));
        chk("t2_done_cnt", 64'(done_cnt), 64'(1));

        // count above RAM depth is clamped
        start_frame(100);
        wait_done(4000);
        tick();
        chk("t3_pulses", 64'(pulse_cnt), 64'(72));
        chk("t3_last_idx", 64'(last_idx), 64'(71));
        chk("t3_done_cnt", 64'(done_cnt), 64'(1));

        // triangle 1 never finishes: abort after 64 raster cycles
        skip_idx = 1;
        start_frame(3);
        wait_valid(1, 500);
        repeat (64) tick();
        chk("t4_err_before", 64'(timeout_err_out), 64'(0));
        chk("t4_busy", 64'(busy_out), 64'(1));
        tick();
        chk("t4_err_set", 64'(timeout_err_out), 64'(1));
        skip_idx = -1;
        wait_done(500);
        tick();
        chk("t4_pulses", 64'(pulse_cnt), 64'(3));
        chk("t4_err_sticky", 64'(timeout_err_out), 64'(1));
        start_frame(1);
        chk("t4_err_cleared", 64'(timeout_err_out), 64'(0));
        wait_done(500);
        tick();

        // restarts and stray lasts are ignored
        model_en = 1'b0;
        start_frame(2);
        wait_valid(0, 500);
        tick();
        tick();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        chk("t5_busy", 64'(busy_out), 64'(1));
        man_last = 1'b1;
        tick();
        tick();
        man_last = 1'b0;
        wait_valid(1, 100);
        tick();
        chk("t5_pulses_mid", 64'(pulse_cnt), 64'(2));
        man_last = 1'b1;
        tick();
        man_last = 1'b0;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        chk("t5_done", 64'(frame_done_out), 64'(1));
        tick();
        chk("t5_not_restarted", 64'(busy_out), 64'(0));
        tick();
        chk("t5_pulses", 64'(pulse_cnt), 64'(2));
        chk("t5_done_cnt", 64'(done_cnt), 64'(1));
        model_en = 1'b1;

        // reset in the middle of rasterizing
        start_frame(3);
        wait_valid(0, 500);
        repeat (3) tick();
        rst_n_in = 1'b0;
        #1;
        chk("t6_busy", 64'(busy_out), 64'(0));
        chk("t6_valid", 64'(rast_valid_out), 64'(0));
        chk("t6_vert_a", 64'(rast_vertex_a_out), 64'(0));
        chk("t6_vert_b", 64'(rast_vertex_b_out), 64'(0));
        chk("t6_vert_c", 64'(rast_vertex_c_out), 64'(0));
`ifdef RASTER_SCHED_CLEAR_EN
        chk("t6_clear_we", 64'(clear_we_out), 64'(0));
`endif
        repeat (12) tick();
        rst_n_in = 1'b1;
        tick();
        start_frame(2);
        wait_valid(0, 500);
`ifdef RASTER_SCHED_CLEAR_EN
        chk("t6_clear_writes", 64'(clr_cnt), 64'(8));
`endif
        wait_done(500);
        tick();
        chk("t6_pulses", 64'(pulse_cnt), 64'(2));
        chk("t6_done_cnt", 64'(done_cnt), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
